// File: rtl/rst_sequencer.sv
// Reset sequencer: releases the memory-controller reset after clock lock, then
// the core/peripheral reset after DDR calibration completes. Debounces the
// board reset button and flags a calibration timeout.
//
// Ports:
//   clk          system clock
//   rstn         async active-low reset (deassertion synchronised internally)
//   rst_btn      raw board reset button, active-high, asynchronous
//   clk_locked   clock-generator lock, asynchronous
//   calib_done   DDR calibration complete, synchronous to clk
//   mig_rst      memory-controller reset, active-high
//   core_rst     core/uncore reset, active-high
//   periph_rstn  peripheral reset, active-low (always !core_rst)
//   calib_err    sticky calibration-timeout flag (set while in ERROR)
//   state_o      current sequencer state encoding
module rst_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES  = 16,
    parameter int unsigned MIG_RST_CYCLES   = 64,
    parameter int unsigned CORE_HOLD_CYCLES = 32,
    parameter int unsigned CALIB_TIMEOUT    = 1048576,
    parameter int unsigned CNT_W            = 24
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rst_btn,
    input  logic       clk_locked,
    input  logic       calib_done,
    output logic       mig_rst,
    output logic       core_rst,
    output logic       periph_rstn,
    output logic       calib_err,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_MIG_RST    = 3'd2,
        ST_WAIT_CALIB = 3'd3,
        ST_CORE_HOLD  = 3'd4,
        ST_RUN        = 3'd5,
        ST_ERROR      = 3'd6
    } state_e;

    // Largest cycle count any counter must represent
    localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > MIG_RST_CYCLES) ? DEBOUNCE_CYCLES : MIG_RST_CYCLES;
    localparam int unsigned MAX_B   = (CORE_HOLD_CYCLES > CALIB_TIMEOUT) ? CORE_HOLD_CYCLES : CALIB_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;

    if ((64'(MAX_CYC) >> CNT_W) != 64'd0) begin : g_cnt_w_check
        $error("rst_sequencer: CNT_W too small for the configured cycle counts");
    end

    // Reset deassertion synchroniser
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Input synchronisers; lock_prev_q extends the lock chain for edge detect
    logic [1:0] btn_sync_q;
    logic [1:0] lock_sync_q;
    logic       lock_prev_q;
    logic       btn_s;
    logic       lock_s;
    logic       lock_fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_sync_q  <= 2'b00;
            lock_sync_q <= 2'b00;
            lock_prev_q <= 1'b0;
        end else begin
            btn_sync_q  <= {btn_sync_q[0], rst_btn};
            lock_sync_q <= {lock_sync_q[0], clk_locked};
            lock_prev_q <= lock_sync_q[1];
        end
    end

    assign btn_s     = btn_sync_q[1];
    assign lock_s    = lock_sync_q[1];
    assign lock_fall = lock_prev_q & ~lock_s;

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive mismatches
    logic             btn_db_q, btn_db_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
        if (!rst_int_n) begin
            btn_db_d = 1'b0;
            db_cnt_d = '0;
        end
    end

    // Sequencer next-state, counter and output decode
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mig_rst_d, core_rst_d, periph_rstn_d, calib_err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE:      state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_s) state_d = ST_MIG_RST;
            ST_MIG_RST: begin
                if (cnt_q == CNT_W'(MIG_RST_CYCLES - 1)) state_d = ST_WAIT_CALIB;
            end
            ST_WAIT_CALIB: begin
                // calib_done takes priority over a coincident timeout
                if (calib_done) begin
                    state_d = ST_CORE_HOLD;
                end else if (cnt_q == CNT_W'(CALIB_TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end
            end
            ST_CORE_HOLD: begin
                if (cnt_q == CNT_W'(CORE_HOLD_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase

        // Button or lock loss restarts the sequence; button holds it in WAIT_LOCK
        if ((state_q != ST_IDLE) && (btn_db_q || lock_fall)) begin
            state_d = ST_WAIT_LOCK;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if (!rst_int_n) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        // Outputs registered from the next state so they track state_q exactly
        mig_rst_d     = (state_d == ST_IDLE) || (state_d == ST_WAIT_LOCK) || (state_d == ST_MIG_RST);
        core_rst_d    = (state_d != ST_RUN);
        periph_rstn_d = (state_d == ST_RUN);
        calib_err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_db_q    <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mig_rst     <= 1'b1;
            core_rst    <= 1'b1;
            periph_rstn <= 1'b0;
            calib_err   <= 1'b0;
        end else begin
            btn_db_q    <= btn_db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mig_rst     <= mig_rst_d;
            core_rst    <= core_rst_d;
            periph_rstn <= periph_rstn_d;
            calib_err   <= calib_err_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Sits directly upstream of the SoC core and memory-controller reset inputs in chip_top.
- Takes the board reset button, the clock-generator lock and the DDR calibration-done flag, and releases resets in order: memory controller first, then core/peripherals.
- Debounces the button and reports a calibration timeout.

Parameters:
- DEBOUNCE_CYCLES, 16, cycles rst_btn must be stable before a change is accepted.
- MIG_RST_CYCLES, 64, cycles mig_rst is held after lock.
- CORE_HOLD_CYCLES, 32, cycles core_rst is held after calibration completes.
- CALIB_TIMEOUT, 1048576, maximum cycles spent in WAIT_CALIB.
- CNT_W, 24, counter width; must satisfy 2^CNT_W > max(all cycle parameters).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised internally by a 2-flop chain
- rst_btn  in  1  raw board reset, active-high (board-level polarity inversion is done outside this block)
- clk_locked  in  1  clock-generator lock, asynchronous, 2-flop synchronised
- calib_done  in  1  DDR calibration complete, synchronous to clk
- mig_rst  out  1  memory-controller reset, active-high
- core_rst  out  1  core/uncore reset, active-high
- periph_rstn  out  1  peripheral reset, active-low; always equals !core_rst
- calib_err  out  1  sticky calibration-timeout flag
- state_o  out  3  current FSM state encoding

Behaviour:
- Reset (rstn low, and until the internal 2-flop synchronised rstn has deasserted):
  - mig_rst=1, core_rst=1, periph_rstn=0, calib_err=0, state_o=IDLE(0).
  - All counters are 0 and the debounced button is 0.
- Debouncer:
  - Takes rst_btn through a 2-flop synchroniser.
  - btn_db changes only after the synchronised value has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch gap restarts the count.
- FSM encodings: IDLE=0, WAIT_LOCK=1, MIG_RST=2, WAIT_CALIB=3, CORE_HOLD=4, RUN=5, ERROR=6.
  - IDLE: always moves to WAIT_LOCK on the next cycle.
  - WAIT_LOCK: mig_rst=1, core_rst=1. Moves to MIG_RST when the synchronised clk_locked=1; the counter clears.
  - MIG_RST: mig_rst=1, core_rst=1. The counter counts to MIG_RST_CYCLES-1, then the FSM moves to WAIT_CALIB. mig_rst deasserts on the cycle of entry to WAIT_CALIB, so it is high for exactly MIG_RST_CYCLES cycles in MIG_RST.
  - WAIT_CALIB: mig_rst=0, core_rst=1.
    - calib_done=1 -> CORE_HOLD.
    - Counter reaching CALIB_TIMEOUT-1 without calib_done -> ERROR.
    - If calib_done rises on the timeout cycle, calib_done wins.
  - CORE_HOLD: mig_rst=0, core_rst=1. Counts CORE_HOLD_CYCLES, then moves to RUN. core_rst deasserts on RUN entry.
  - RUN: all resets released. Stays in RUN.
  - ERROR: mig_rst=0, core_rst=1, calib_err=1. Stays in ERROR until a button press or lock loss.
- Global abort conditions, evaluated in any state other than IDLE:
  - btn_db=1 -> WAIT_LOCK, with mig_rst=1 and core_rst=1 on the next cycle; calib_err clears.
  - Synchronised clk_locked falling -> the same action.
  - While btn_db=1, the FSM is held in WAIT_LOCK.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Counters saturate and never wrap: they clear on every state entry, and the CNT_W check is done at elaboration.
- calib_done dropping during CORE_HOLD or RUN is ignored; the controller handles recalibration itself.
- rstn assertion mid-sequence forces reset values immediately (asynchronously). Deassertion restarts the sequence from IDLE two cycles later.

Test Plan:
- Power-up with clk_locked=1 from t0 and calib_done rising 100 cycles after WAIT_CALIB entry:
  - mig_rst falls 64 cycles after MIG_RST entry.
  - core_rst falls 32 cycles after calib_done.
  - state_o ends at 5.
- Button glitches of 5, 10 and 15 cycles while in RUN -> no state change. A 16-cycle press -> core_rst and mig_rst high within 16+2+1 cycles, then the full sequence repeats after release.
- calib_done held at 0 (CALIB_TIMEOUT overridden to 1000):
  - ERROR entered after exactly 1000 cycles in WAIT_CALIB, with calib_err=1 and core_rst=1.
  - A subsequent debounced press clears calib_err and restarts the sequence.
- clk_locked dropped for 3 cycles during CORE_HOLD -> return to WAIT_LOCK with mig_rst=1; the sequence resumes when lock returns.
- rstn pulsed low for 1 cycle mid-MIG_RST -> outputs reach reset values in the same cycle (asynchronously); state_o=0 and the sequence restarts.
- calib_done asserted on the exact timeout cycle -> CORE_HOLD is entered and calib_err stays 0.
